// File: rtl/datapath_ctrl_pkg.sv
// Shared types and encodings for the datapath controller: FSM states,
// instruction opcode/op constants, ALU and shifter operation codes, and the
// decoded-instruction record passed from instr_dec to the controller.
package datapath_ctrl_pkg;

  typedef enum logic [2:0] {
    S_WAIT      = 3'd0,
    S_DECODE    = 3'd1,
    S_GET_A     = 3'd2,
    S_GET_B     = 3'd3,
    S_EXEC      = 3'd4,
    S_WRITE_REG = 3'd5,
    S_WRITE_IMM = 3'd6
  } state_e;

  // Opcode field [15:13]
  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;

  // Op field [12:11] qualifiers for the MOV opcode
  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_MOV_IMM = 2'b10;

  // ALUop encodings; for OPC_ALU the op field is used directly as ALUop
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;  // CMP uses SUB and only updates status
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_MVN = 2'b11;

  // Shifter encodings carried in the sh field
  localparam logic [1:0] SH_NONE = 2'b00;
  localparam logic [1:0] SH_LSL  = 2'b01;
  localparam logic [1:0] SH_LSR  = 2'b10;
  localparam logic [1:0] SH_ASR  = 2'b11;

  // Decoded view of a 16-bit instruction word
  typedef struct packed {
    logic [2:0]  opcode;
    logic [1:0]  op;
    logic [2:0]  rn;
    logic [2:0]  rd;
    logic [1:0]  sh;
    logic [2:0]  rm;
    logic [15:0] imm_sext;
  } instr_fields_t;

endpackage

// File: rtl/datapath_ctrl_instr_dec.sv
// Purely combinational instruction field extraction and imm8 sign extension.
module instr_dec
  import datapath_ctrl_pkg::*;
(
  input  logic [15:0]   instr,
  output instr_fields_t fields
);

  // Slice the fixed instruction fields and sign-extend imm8 to 16 bits
  always_comb begin
    fields          = '0;
    fields.opcode   = instr[15:13];
    fields.op       = instr[12:11];
    fields.rn       = instr[10:8];
    fields.rd       = instr[7:5];
    fields.sh       = instr[4:3];
    fields.rm       = instr[2:0];
    fields.imm_sext = {{8{instr[7]}}, instr[7:0]};
  end

endmodule

// File: rtl/datapath_ctrl.sv
// Moore controller sequencing a register-file/ALU datapath through
// decode, operand fetch, execute and write-back for MOV/ADD/CMP/AND/MVN.
//
// Start handshake: w=1 means the controller sits in WAIT and is ready; a
// start is accepted on any rising clk edge where w=1 and s=1, and instr is
// captured into IR on that same edge. s is ignored whenever w=0. Holding s
// high chains instructions with no idle cycle between them.
//
// Only state and IR are registered; every datapath control is a pure
// function of (state, IR), so reset clears the outputs immediately.
module datapath_ctrl
  import datapath_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        s,
  input  logic [15:0] instr,
  output logic        w,
  output logic [2:0]  readnum,
  output logic [2:0]  writenum,
  output logic        write,
  output logic        loada,
  output logic        loadb,
  output logic        loadc,
  output logic        loads,
  output logic        asel,
  output logic        bsel,
  output logic        vsel,
  output logic [1:0]  shift,
  output logic [1:0]  ALUop,
  output logic [15:0] datapath_in,
  output logic [2:0]  dbg_state
);

  state_e        state_q, state_d;
  logic [15:0]   ir_q, ir_d;
  instr_fields_t f;

  logic is_mov_imm, is_mov_reg, is_alu, is_cmp;

  instr_dec u_instr_dec (
    .instr  (ir_q),
    .fields (f)
  );

  // Instruction class flags derived from the latched IR
  always_comb begin
    is_mov_imm = (f.opcode == OPC_MOV) && (f.op == OP_MOV_IMM);
    is_mov_reg = (f.opcode == OPC_MOV) && (f.op == OP_MOV_REG);
    is_alu     = (f.opcode == OPC_ALU);
    is_cmp     = is_alu && (f.op == ALU_SUB);
  end

  // Next-state and IR capture
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    unique case (state_q)
      S_WAIT: begin
        if (s) begin
          ir_d    = instr;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (is_mov_imm)      state_d = S_WRITE_IMM;
        else if (is_mov_reg) state_d = S_GET_B;
        else if (is_alu)     state_d = S_GET_A;
        else                 state_d = S_WAIT;  // unsupported: drop it, no write
      end
      S_GET_A:     state_d = S_GET_B;
      S_GET_B:     state_d = S_EXEC;
      S_EXEC:      state_d = is_cmp ? S_WAIT : S_WRITE_REG;
      S_WRITE_REG: state_d = S_WAIT;
      S_WRITE_IMM: state_d = S_WAIT;
      default:     state_d = S_WAIT;
    endcase
  end

  // State and IR registers, cleared asynchronously
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_WAIT;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  // Moore output decode: everything not driven by the current state is 0
  always_comb begin
    w           = 1'b0;
    readnum     = 3'd0;
    writenum    = 3'd0;
    write       = 1'b0;
    loada       = 1'b0;
    loadb       = 1'b0;
    loadc       = 1'b0;
    loads       = 1'b0;
    asel        = 1'b0;
    bsel        = 1'b0;
    vsel        = 1'b0;
    shift       = SH_NONE;
    ALUop       = ALU_ADD;
    datapath_in = 16'd0;
    unique case (state_q)
      S_WAIT: w = 1'b1;
      S_DECODE: ;
      S_GET_A: begin
        readnum = f.rn;
        loada   = 1'b1;
      end
      S_GET_B: begin
        readnum = f.rm;
        loadb   = 1'b1;
      end
      S_EXEC: begin
        shift = f.sh;
        bsel  = 1'b0;
        loadc = 1'b1;
        // MOV reg passes shifted B through an ADD with A forced to zero
        asel  = is_mov_reg;
        ALUop = is_alu ? f.op : ALU_ADD;
        loads = is_cmp;
      end
      S_WRITE_REG: begin
        writenum = f.rd;
        vsel     = 1'b0;
        write    = 1'b1;
      end
      S_WRITE_IMM: begin
        writenum    = f.rn;
        vsel        = 1'b1;
        write       = 1'b1;
        datapath_in = f.imm_sext;
      end
      default: ;
    endcase
  end

  assign dbg_state = state_q;

endmodule

// File: tb/tb_datapath_ctrl.sv
// Directed testbench for datapath_ctrl: walks each instruction class cycle by
// cycle and compares every control output against hand-computed values.
module tb_datapath_ctrl;
  import datapath_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        s;
  logic [15:0] instr;
  logic        w;
  logic [2:0]  readnum;
  logic [2:0]  writenum;
  logic        write;
  logic        loada;
  logic        loadb;
  logic        loadc;
  logic        loads;
  logic        asel;
  logic        bsel;
  logic        vsel;
  logic [1:0]  shift;
  logic [1:0]  ALUop;
  logic [15:0] datapath_in;
  logic [2:0]  dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  // Packed control snapshot:
  // {w, write, loada, loadb, loadc, loads, asel, bsel, vsel, readnum, writenum, shift, ALUop}
  localparam logic [18:0] CTL_WAIT = 19'h40000;
  localparam logic [18:0] CTL_ZERO = 19'h00000;
  logic [18:0] ctl_obs;

  datapath_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .s           (s),
    .instr       (instr),
    .w           (w),
    .readnum     (readnum),
    .writenum    (writenum),
    .write       (write),
    .loada       (loada),
    .loadb       (loadb),
    .loadc       (loadc),
    .loads       (loads),
    .asel        (asel),
    .bsel        (bsel),
    .vsel        (vsel),
    .shift       (shift),
    .ALUop       (ALUop),
    .datapath_in (datapath_in),
    .dbg_state   (dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  assign ctl_obs = {w, write, loada, loadb, loadc, loads, asel, bsel, vsel,
                    readnum, writenum, shift, ALUop};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [18:0] ctl(input logic w_e, input logic wr, input logic la,
                                      input logic lb, input logic lc, input logic ls,
                                      input logic as_e, input logic bs_e, input logic vs_e,
                                      input logic [2:0] rn, input logic [2:0] wn,
                                      input logic [1:0] sh, input logic [1:0] alu);
    return {w_e, wr, la, lb, lc, ls, as_e, bs_e, vs_e, rn, wn, sh, alu};
  endfunction

  // Compare the full control snapshot and datapath_in for the current cycle
  task automatic expect_cyc(input string tag, input logic [18:0] e, input logic [15:0] dpin);
    check({tag, "/ctl"}, 32'(ctl_obs), 32'(e));
    check({tag, "/dpin"}, 32'(datapath_in), 32'(dpin));
  endtask

  // Advance one cycle; outputs are sampled 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present instr with s for one accepting edge, then scramble instr
  task automatic start(input logic [15:0] iw);
    s     = 1'b1;
    instr = iw;
    tick();
    s     = 1'b0;
    instr = 16'($urandom_range(0, 65535));
  endtask

  initial begin
    reset = 1'b1;
    s     = 1'b0;
    instr = 16'h0000;
    #2;
    expect_cyc("reset", CTL_WAIT, 16'h0000);
    check("reset/state", 32'(dbg_state), 32'(S_WAIT));
    tick();
    tick();
    reset = 1'b0;

    // MOV R0,#7: start on the very first edge after reset release
    expect_cyc("mov7/wait", CTL_WAIT, 16'h0000);
    start(16'hD007);
    expect_cyc("mov7/decode", CTL_ZERO, 16'h0000);
    tick();
    expect_cyc("mov7/wimm", ctl(0,1,0,0,0,0,0,0,1,3'd0,3'd0,2'b00,2'b00), 16'h0007);
    tick();
    expect_cyc("mov7/done", CTL_WAIT, 16'h0000);

    // MOV R1,#-2
    start(16'hD1FE);
    expect_cyc("movm2/decode", CTL_ZERO, 16'h0000);
    tick();
    expect_cyc("movm2/wimm", ctl(0,1,0,0,0,0,0,0,1,3'd0,3'd1,2'b00,2'b00), 16'hFFFE);
    tick();
    expect_cyc("movm2/done", CTL_WAIT, 16'h0000);

    // Sign-extension boundaries: MOV R7,#127 and MOV R6,#-128
    start(16'hD77F);
    tick();
    expect_cyc("mov127/wimm", ctl(0,1,0,0,0,0,0,0,1,3'd0,3'd7,2'b00,2'b00), 16'h007F);
    tick();
    start(16'hD680);
    tick();
    expect_cyc("movm128/wimm", ctl(0,1,0,0,0,0,0,0,1,3'd0,3'd6,2'b00,2'b00), 16'hFF80);
    tick();
    expect_cyc("movm128/done", CTL_WAIT, 16'h0000);

    // ADD R2,R1,R0,LSL#1
    start(16'hA148);
    expect_cyc("add/decode", CTL_ZERO, 16'h0000);
    tick();
    expect_cyc("add/geta", ctl(0,0,1,0,0,0,0,0,0,3'd1,3'd0,2'b00,2'b00), 16'h0000);
    tick();
    expect_cyc("add/getb", ctl(0,0,0,1,0,0,0,0,0,3'd0,3'd0,2'b00,2'b00), 16'h0000);
    tick();
    expect_cyc("add/exec", ctl(0,0,0,0,1,0,0,0,0,3'd0,3'd0,2'b01,2'b00), 16'h0000);
    tick();
    expect_cyc("add/wreg", ctl(0,1,0,0,0,0,0,0,0,3'd0,3'd2,2'b00,2'b00), 16'h0000);
    tick();
    expect_cyc("add/done", CTL_WAIT, 16'h0000);

    // CMP R1,R0: status load only, no write, idle after 5 cycles
    start(16'hA900);
    expect_cyc("cmp/decode", CTL_ZERO, 16'h0000);
    tick();
    expect_cyc("cmp/geta", ctl(0,0,1,0,0,0,0,0,0,3'd1,3'd0,2'b00,2'b00), 16'h0000);
    tick();
    expect_cyc("cmp/getb", ctl(0,0,0,1,0,0,0,0,0,3'd0,3'd0,2'b00,2'b00), 16'h0000);
    tick();
    expect_cyc("cmp/exec", ctl(0,0,0,0,1,1,0,0,0,3'd0,3'd0,2'b00,2'b01), 16'h0000);
    tick();
    expect_cyc("cmp/done", CTL_WAIT, 16'h0000);

    // MOV R3,R5,LSR with s held high mid-instruction (must be ignored)
    start(16'hC075);
    s     = 1'b1;
    instr = 16'hD007;
    expect_cyc("movr/decode", CTL_ZERO, 16'h0000);
    tick();
    expect_cyc("movr/getb", ctl(0,0,0,1,0,0,0,0,0,3'd5,3'd0,2'b00,2'b00), 16'h0000);
    tick();
    expect_cyc("movr/exec", ctl(0,0,0,0,1,0,1,0,0,3'd0,3'd0,2'b10,2'b00), 16'h0000);
    tick();
    expect_cyc("movr/wreg", ctl(0,1,0,0,0,0,0,0,0,3'd0,3'd3,2'b00,2'b00), 16'h0000);
    s = 1'b0;
    tick();
    expect_cyc("movr/done", CTL_WAIT, 16'h0000);

    // MVN R4,R2
    start(16'hB882);
    tick();
    expect_cyc("mvn/geta", ctl(0,0,1,0,0,0,0,0,0,3'd0,3'd0,2'b00,2'b00), 16'h0000);
    tick();
    expect_cyc("mvn/getb", ctl(0,0,0,1,0,0,0,0,0,3'd2,3'd0,2'b00,2'b00), 16'h0000);
    tick();
    expect_cyc("mvn/exec", ctl(0,0,0,0,1,0,0,0,0,3'd0,3'd0,2'b00,2'b11), 16'h0000);
    tick();
    expect_cyc("mvn/wreg", ctl(0,1,0,0,0,0,0,0,0,3'd0,3'd4,2'b00,2'b00), 16'h0000);
    tick();
    expect_cyc("mvn/done", CTL_WAIT, 16'h0000);

    // Unsupported encodings: decode then straight back to WAIT, no write
    start(16'h0000);
    expect_cyc("unsup0/decode", CTL_ZERO, 16'h0000);
    tick();
    expect_cyc("unsup0/done", CTL_WAIT, 16'h0000);
    start(16'hC800);
    expect_cyc("unsupc8/decode", CTL_ZERO, 16'h0000);
    tick();
    expect_cyc("unsupc8/done", CTL_WAIT, 16'h0000);

    // Back-to-back MOV imm with s held high: writes 3 cycles apart
    s     = 1'b1;
    instr = 16'hD007;
    tick();
    expect_cyc("b2b/decode1", CTL_ZERO, 16'h0000);
    tick();
    expect_cyc("b2b/wimm1", ctl(0,1,0,0,0,0,0,0,1,3'd0,3'd0,2'b00,2'b00), 16'h0007);
    tick();
    expect_cyc("b2b/wait", CTL_WAIT, 16'h0000);
    instr = 16'hD1FE;
    tick();
    s = 1'b0;
    expect_cyc("b2b/decode2", CTL_ZERO, 16'h0000);
    tick();
    expect_cyc("b2b/wimm2", ctl(0,1,0,0,0,0,0,0,1,3'd0,3'd1,2'b00,2'b00), 16'hFFFE);
    tick();
    expect_cyc("b2b/done", CTL_WAIT, 16'h0000);

    // Reset during GET_B of ADD: immediate idle, no later write
    start(16'hA148);
    tick();
    tick();
    expect_cyc("rst/getb", ctl(0,0,0,1,0,0,0,0,0,3'd0,3'd0,2'b00,2'b00), 16'h0000);
    #1;
    reset = 1'b1;
    #1;
    expect_cyc("rst/async", CTL_WAIT, 16'h0000);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      expect_cyc("rst/after", CTL_WAIT, 16'h0000);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
